// File: rtl/bin2dec_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bin2dec_display_ctrl                                         |
// | Description : Sequential binary-to-BCD conversion feeding a multiplexed,   |
// |               leading-zero-blanked seven-segment display scanner.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bin2dec_display_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int          REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = 64'(pow10(NUM_DIGITS) - 1);

  localparam logic [6:0] C_SEG_DASH  = 7'b0111111;
  localparam logic [6:0] C_SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = C_SEG_BLANK;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf_pend;
  logic [BCD_W-1:0]   r_disp;
  logic [REF_W-1:0]   r_refresh;
  logic [IDX_W-1:0]   r_idx;

  logic [BCD_W-1:0]      w_adj;
  logic [3:0]            w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_too_big;
  logic [6:0]            w_seg_next;

  assign w_too_big = (64'(value) > MAX_VAL);
  assign dp        = 1'b1;

  // Per-digit add-3 correction and display view; w_blank marks digits above
  // the most significant nonzero one (digit 0 is always shown).
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
    assign w_nib[i] = r_disp[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign w_blank[i] = 1'b0;
    end else if (i == NUM_DIGITS - 1) begin : g_msd
      assign w_blank[i] = (r_disp[4*i +: 4] == 4'd0);
    end else begin : g_mid
      assign w_blank[i] = (r_disp[4*i +: 4] == 4'd0) && w_blank[i+1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_count    <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_count    <= CNT_W'(BIN_W);
            r_ovf_pend <= w_too_big;
            busy       <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd   <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin   <= {r_bin[BIN_W-2:0], 1'b0};
          r_count <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          // Display registers update in one edge so no partial result shows.
          r_disp   <= r_bcd;
          overflow <= r_ovf_pend;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_seg_next = seg_code(w_nib[r_idx]);
    if (overflow)            w_seg_next = C_SEG_DASH;
    else if (w_blank[r_idx]) w_seg_next = C_SEG_BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
      an        <= '1;
      seg       <= C_SEG_BLANK;
    end else begin
      if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_idx     <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      an  <= ~(NUM_DIGITS'(1) << r_idx);
      seg <= w_seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2dec_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bin2dec_display_ctrl                                      |
// | Description : Directed, table-driven bench for bin2dec_display_ctrl.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bin2dec_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000,
                         SD = 7'b0111111, SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [13:0] value;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int tests = 0;
  int fails = 0;

  bin2dec_display_ctrl #(
    .NUM_DIGITS (4),
    .BIN_W      (14),
    .REFRESH_DIV(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .value   (value),
    .busy    (busy),
    .overflow(overflow),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               v;
    logic [3:0][6:0]  segs;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Load v; optionally pulse load (value 5555) in busy cycles pa/pb; returns busy length.
  task automatic run_conv(input int v, input int pa, input int pb, output int blen);
    @(posedge clk); #1 value = 14'(v); load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    blen = 0;
    for (int c = 1; c <= 60; c++) begin
      load = (c == pa) || (c == pb);
      if (load) value = 14'd5555;
      @(negedge clk);
      if (!busy) break;
      blen++;
      @(posedge clk); #1;
    end
    load = 1'b0;
  endtask

  task automatic check_display(input string tag, input logic [3:0][6:0] exp, input logic exp_ovf);
    int zeros;
    int idx;
    @(posedge clk);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      zeros = 0;
      idx   = 0;
      for (int d = 0; d < 4; d++) if (an[d] == 1'b0) begin zeros++; idx = d; end
      chk($sformatf("%s an_onehot", tag), zeros, 1);
      if (zeros == 1) chk($sformatf("%s seg_digit%0d", tag, idx), {25'd0, seg}, {25'd0, exp[idx]});
    end
    chk($sformatf("%s overflow", tag), {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    int blen;
    int dig;
    int busy_seen;

    vecs[0] = '{v: 1234,  segs: {S1, S2, S3, S4}, ovf: 1'b0};
    vecs[1] = '{v: 7,     segs: {SB, SB, SB, S7}, ovf: 1'b0};
    vecs[2] = '{v: 12000, segs: {SD, SD, SD, SD}, ovf: 1'b1};
    vecs[3] = '{v: 9999,  segs: {S9, S9, S9, S9}, ovf: 1'b0};
    vecs[4] = '{v: 10000, segs: {SD, SD, SD, SD}, ovf: 1'b1};
    vecs[5] = '{v: 1005,  segs: {S1, S0, S0, S5}, ovf: 1'b0};
    vecs[6] = '{v: 80,    segs: {SB, SB, S8, S0}, ovf: 1'b0};
    vecs[7] = '{v: 16383, segs: {SD, SD, SD, SD}, ovf: 1'b1};

    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst an", {28'd0, an}, 32'hF);
    chk("rst seg", {25'd0, seg}, {25'd0, SB});
    chk("rst dp", {31'd0, dp}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);

    @(negedge clk) reset = 1'b0;
    #1 chk("release an", {28'd0, an}, 32'hF);

    // Scan from reset: each anode held 4 cycles in order 0..3, value shows "0".
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      dig = ((n - 1) / 4) % 4;
      chk($sformatf("idle an c%0d", n), {28'd0, an}, {28'd0, ~(4'b0001 << dig)});
      chk($sformatf("idle seg c%0d", n), {25'd0, seg}, {25'd0, (dig == 0) ? S0 : SB});
    end
    chk("idle busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].v, 0, 0, blen);
      chk($sformatf("v%0d busy_len", vecs[i].v), blen, 15);
      check_display($sformatf("v%0d", vecs[i].v), vecs[i].segs, vecs[i].ovf);
    end

    // Loads during busy must be ignored without changing latency.
    run_conv(1234, 3, 10, blen);
    chk("ignore busy_len", blen, 15);
    check_display("ignore", {S1, S2, S3, S4}, 1'b0);

    // Reset mid-conversion aborts with no commit.
    @(posedge clk); #1 value = 14'd4321; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (5) @(posedge clk);
    #2 chk("midrst busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst an", {28'd0, an}, 32'hF);
    chk("midrst seg", {25'd0, seg}, {25'd0, SB});
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk("midrst release an", {28'd0, an}, 32'hF);
    check_display("midrst", {SB, SB, SB, S0}, 1'b0);
    busy_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("midrst no_busy", busy_seen, 0);
    check_display("midrst after", {SB, SB, SB, S0}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
